// File: rtl/inst_fetch_bus_if_if.sv
// Wishbone-classic read bus bundle used by the instruction fetch master.
//
// Signals:
//   wb_adr_o  32  bus address            (master -> slave)
//   wb_dat_i  32  bus read data          (slave  -> master)
//   wb_ack_i   1  bus acknowledge        (slave  -> master)
//   wb_cyc_o   1  bus cycle valid        (master -> slave)
//   wb_stb_o   1  bus strobe             (master -> slave)
//   wb_we_o    1  write enable, always 0 (master -> slave)
//   wb_sel_o   4  byte selects           (master -> slave)
interface inst_fetch_bus_if_if;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;

    modport master (
        output wb_adr_o,
        input  wb_dat_i,
        input  wb_ack_i,
        output wb_cyc_o,
        output wb_stb_o,
        output wb_we_o,
        output wb_sel_o
    );

    modport slave (
        input  wb_adr_o,
        output wb_dat_i,
        output wb_ack_i,
        input  wb_cyc_o,
        input  wb_stb_o,
        input  wb_we_o,
        input  wb_sel_o
    );
endinterface

// File: rtl/inst_fetch_bus_if.sv
// Instruction-side Wishbone-classic bus master sitting right after the PC
// register. Turns a pc/ce request into a single-beat read, forwards the
// fetched word to the IF/ID register, requests a pipeline stall while the
// bus is slow, honours pipeline flush and aborts hung cycles on timeout.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   stall[5:0]  pipeline stall vector (stall[1] = IF held)
//   flush       pipeline flush
//   cpu_ce_i    fetch enable from PC stage
//   cpu_addr_i  fetch address from PC stage
//   cpu_data_o  instruction to IF/ID register
//   stallreq_o  fetch stall request
//   bus_err_o   one-cycle pulse on timeout abort
//   wb          Wishbone master port (see inst_fetch_bus_if_if)
module inst_fetch_bus_if #(
    parameter int unsigned TIMEOUT_CYCLES = 255,   // 0 disables, max 255
    parameter logic [31:0] NOP_WORD       = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [5:0]                 stall,
    input  logic                       flush,
    input  logic                       cpu_ce_i,
    input  logic [31:0]                cpu_addr_i,
    output logic [31:0]                cpu_data_o,
    output logic                       stallreq_o,
    output logic                       bus_err_o,
    inst_fetch_bus_if_if.master        wb
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        WAIT_STALL
    } state_t;

    localparam bit         TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] TIMEOUT_LAST = TIMEOUT_EN ? 8'(TIMEOUT_CYCLES - 1) : 8'd0;

    state_t      state;
    logic [31:0] rd_buf;    // word held while the pipeline is stalled
    logic [7:0]  timer;     // BUSY cycles elapsed without ack

    // Read-only master.
    assign wb.wb_we_o = 1'b0;

    // NOTE: every register here is written with <= so all of them update
    // from the same pre-edge values; blocking writes would make later
    // statements see half-updated state.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Dropping cyc/stb here also means an ack arriving after reset
            // has nothing to match and is ignored.
            state       <= IDLE;
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
            wb.wb_adr_o <= 32'h0;
            wb.wb_sel_o <= 4'b0000;
            bus_err_o   <= 1'b0;
            rd_buf      <= NOP_WORD;
            timer       <= 8'd0;
        end else begin
            bus_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_ce_i && !flush) begin
                        wb.wb_cyc_o <= 1'b1;
                        wb.wb_stb_o <= 1'b1;
                        wb.wb_adr_o <= cpu_addr_i;
                        wb.wb_sel_o <= 4'b1111;
                        timer       <= 8'd0;
                        state       <= BUSY;
                    end
                end

                BUSY: begin
                    if (flush) begin
                        // A same-cycle ack is deliberately thrown away.
                        wb.wb_cyc_o <= 1'b0;
                        wb.wb_stb_o <= 1'b0;
                        wb.wb_sel_o <= 4'b0000;
                        wb.wb_adr_o <= 32'h0;
                        state       <= IDLE;
                    end else if (wb.wb_ack_i) begin
                        wb.wb_cyc_o <= 1'b0;
                        wb.wb_stb_o <= 1'b0;
                        wb.wb_sel_o <= 4'b0000;
                        wb.wb_adr_o <= 32'h0;
                        rd_buf      <= wb.wb_dat_i;
                        // The word was forwarded this cycle; if IF is held it
                        // must be replayed from the buffer until released.
                        state       <= (stall != 6'd0) ? WAIT_STALL : IDLE;
                    end else if (TIMEOUT_EN && timer == TIMEOUT_LAST) begin
                        wb.wb_cyc_o <= 1'b0;
                        wb.wb_stb_o <= 1'b0;
                        wb.wb_sel_o <= 4'b0000;
                        wb.wb_adr_o <= 32'h0;
                        rd_buf      <= NOP_WORD;
                        bus_err_o   <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        // Address stays as captured; pc changes are ignored.
                        timer <= timer + 8'd1;
                    end
                end

                WAIT_STALL: begin
                    if (flush) begin
                        rd_buf <= NOP_WORD;
                        state  <= IDLE;
                    end else if (stall == 6'd0) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: both outputs get a default before the case so no path leaves
    // them unassigned, which would otherwise infer a latch.
    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = NOP_WORD;
        case (state)
            BUSY: begin
                if (wb.wb_ack_i && !flush) begin
                    // Zero-latency forward of the bus data.
                    cpu_data_o = wb.wb_dat_i;
                end else begin
                    stallreq_o = !flush;
                end
            end
            WAIT_STALL: cpu_data_o = rd_buf;
            default: ;
        endcase
    end

endmodule
